// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan display.
// Segment glyph table, blank codes and the decimal-point bit position.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'hF;
  localparam int         DP_BIT    = 7;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F.
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_scan_display_hex_to_seg.sv
// Nibble to active-low seven-segment glyph.
// Purely combinational; shared with the ALU top.
import seg_pkg::*;

module hex_to_seg (
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = GLYPH[i_nib];

endmodule

// File: rtl/seg_scan_display.sv
// Snapshots an ALU result and scans one 16-bit page onto a 4-digit display.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits of the page.
import seg_pkg::*;

module seg_scan_display #(
  parameter int SCAN_DIV = 50000,
  parameter int DIV_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] result,
  input  logic        ovf,
  input  logic        load,
  input  logic        page_btn,
  output logic [3:0]  AN,
  output logic [7:0]  seg
);

  logic [31:0]      r_snap;
  logic             r_snap_ovf;
  logic             r_page;
  logic [DIV_W-1:0] r_div_cnt;
  logic [1:0]       r_idx;
  logic [1:0]       r_sync;
  logic             r_sync_d;

  logic        w_btn_rise;
  logic        w_wrap;
  logic [15:0] w_win;
  logic [15:0] w_shift;
  logic [6:0]  w_glyph;
  logic        w_dp;
  logic        w_blank;
  logic [3:0]  w_an;
  logic [7:0]  w_seg;

  assign w_btn_rise = r_sync[1] & ~r_sync_d;
  assign w_wrap     = (r_div_cnt == DIV_W'(SCAN_DIV - 1));

  assign w_win   = r_page ? r_snap[31:16] : r_snap[15:0];
  assign w_shift = w_win >> {r_idx, 2'b00};

  assign w_dp = ((r_idx == 2'd3) && r_page) ||
                ((r_idx == 2'd0) && r_snap_ovf);

`ifdef LEADING_ZERO_BLANK_EN
  // Slot is a leading zero when it and every higher nibble are zero.
  assign w_blank = (r_idx != 2'd0) && (w_shift == 16'h0) && !w_dp;
`else
  assign w_blank = 1'b0;
`endif

  hex_to_seg u_hex (
    .i_nib (w_shift[3:0]),
    .o_seg (w_glyph)
  );

  always_comb begin
    w_an  = ~(4'b0001 << r_idx);
    w_seg = {~w_dp, w_glyph};
    if (w_blank) begin
      w_an  = AN_OFF;
      w_seg = SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap     <= '0;
      r_snap_ovf <= 1'b0;
      r_page     <= 1'b0;
      r_div_cnt  <= '0;
      r_idx      <= '0;
      r_sync     <= '0;
      r_sync_d   <= 1'b0;
      AN         <= AN_OFF;
      seg        <= SEG_BLANK;
    end else begin
      r_sync   <= {r_sync[0], page_btn};
      r_sync_d <= r_sync[1];
      if (w_btn_rise)
        r_page <= ~r_page;
      if (load) begin
        r_snap     <= result;
        r_snap_ovf <= ovf;
      end
      if (w_wrap) begin
        r_div_cnt <= '0;
        r_idx     <= r_idx + 2'd1;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
      AN  <= w_an;
      seg <= w_seg;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with a fast scan (SCAN_DIV=4).
// Define LEADING_ZERO_BLANK_EN to also cover leading-zero blanking.
module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] result = '0;
  logic        ovf = 1'b0;
  logic        load = 1'b0;
  logic        page_btn = 1'b0;
  logic [3:0]  AN;
  logic [7:0]  seg;

  int n_chk = 0;
  int n_err = 0;

  seg_scan_display #(.SCAN_DIV(4), .DIV_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .result   (result),
    .ovf      (ovf),
    .load     (load),
    .page_btn (page_btn),
    .AN       (AN),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_an(input logic [3:0] an, input string tag);
    for (int i = 0; i < 20; i++) begin
      if (AN == an) break;
      @(negedge clk);
    end
    chk({tag, "_an"}, 32'(AN), 32'(an));
  endtask

  task automatic do_load(input logic [31:0] r, input logic o);
    result = r;
    ovf    = o;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic pulse_btn();
    page_btn = 1'b1;
    repeat (2) @(negedge clk);
    page_btn = 1'b0;
  endtask

  logic [3:0] exp_an [4];
  logic [7:0] exp_sg [4];
  int         n_on;

  initial begin
    // reset
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(AN), 32'hF);
    chk("rst_seg", 32'(seg), 32'hFF);
    rst = 1'b0;
    @(negedge clk);
    chk("first_an", 32'(AN), 32'hE);
    chk("first_seg", 32'(seg), 32'hC0);

    // scan order with a zero snapshot
`ifdef LEADING_ZERO_BLANK_EN
    exp_an = '{4'hF, 4'hF, 4'hF, 4'hE};
    exp_sg = '{8'hFF, 8'hFF, 8'hFF, 8'hC0};
`else
    exp_an = '{4'hD, 4'hB, 4'h7, 4'hE};
    exp_sg = '{8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif
    for (int k = 0; k < 4; k++) begin
      repeat (4) @(negedge clk);
      chk($sformatf("scan%0d_an", k), 32'(AN), 32'(exp_an[k]));
      chk($sformatf("scan%0d_seg", k), 32'(seg), 32'(exp_sg[k]));
    end

    // page 0 of 0000ABCD
    do_load(32'h0000_ABCD, 1'b0);
    @(negedge clk);
    wait_an(4'hE, "abcd0"); chk("abcd0_seg", 32'(seg), 32'hA1);
    wait_an(4'hD, "abcd1"); chk("abcd1_seg", 32'(seg), 32'hC6);
    wait_an(4'hB, "abcd2"); chk("abcd2_seg", 32'(seg), 32'h83);
    wait_an(4'h7, "abcd3"); chk("abcd3_seg", 32'(seg), 32'h88);

    // upper page with overflow dp
    do_load(32'h1234_0000, 1'b1);
    pulse_btn();
    repeat (4) @(negedge clk);
    wait_an(4'hE, "pg1_0"); chk("pg1_0_seg", 32'(seg), 32'h19);
    wait_an(4'hD, "pg1_1"); chk("pg1_1_seg", 32'(seg), 32'hB0);
    wait_an(4'hB, "pg1_2"); chk("pg1_2_seg", 32'(seg), 32'hA4);
    wait_an(4'h7, "pg1_3"); chk("pg1_3_seg", 32'(seg), 32'h79);
    pulse_btn();
    repeat (4) @(negedge clk);
    wait_an(4'hE, "pg0_0"); chk("pg0_0_seg", 32'(seg), 32'h40);
`ifndef LEADING_ZERO_BLANK_EN
    wait_an(4'h7, "pg0_3"); chk("pg0_3_seg", 32'(seg), 32'hC0);
`endif

    // load coincides with the page toggle; long hold toggles once
    page_btn = 1'b1;
    repeat (2) @(negedge clk);
    result = 32'h5678_9ABC;
    ovf    = 1'b0;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    repeat (2) @(negedge clk);
    wait_an(4'hE, "co0"); chk("co0_seg", 32'(seg), 32'h80);
    wait_an(4'h7, "co3"); chk("co3_seg", 32'(seg), 32'h12);
    repeat (20) @(negedge clk);
    page_btn = 1'b0;
    repeat (4) @(negedge clk);
    wait_an(4'hE, "hold0"); chk("hold0_seg", 32'(seg), 32'h80);
    wait_an(4'hD, "hold1"); chk("hold1_seg", 32'(seg), 32'hF8);

    // reset mid-slot at idx 2
    wait_an(4'hB, "mid");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_an", 32'(AN), 32'hF);
    chk("mid_rst_seg", 32'(seg), 32'hFF);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_an", 32'(AN), 32'hE);
    chk("restart_seg", 32'(seg), 32'hC0);
`ifndef LEADING_ZERO_BLANK_EN
    wait_an(4'h7, "restart3"); chk("restart3_seg", 32'(seg), 32'hC0);
`endif

`ifdef LEADING_ZERO_BLANK_EN
    // only digit 0 remains lit for 0000000F
    do_load(32'h0000_000F, 1'b0);
    repeat (2) @(negedge clk);
    n_on = 0;
    for (int c = 0; c < 16; c++) begin
      if (AN == 4'hE) begin
        n_on++;
        chk("lzb0_seg", 32'(seg), 32'h8E);
      end else begin
        chk("lzb_blank_an", 32'(AN), 32'hF);
        chk("lzb_blank_seg", 32'(seg), 32'hFF);
      end
      @(negedge clk);
    end
    chk("lzb_on_cnt", 32'(n_on), 32'd4);
    do_load(32'h0, 1'b0);
    repeat (2) @(negedge clk);
    wait_an(4'hE, "lzbz"); chk("lzbz_seg", 32'(seg), 32'hC0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Downstream consumer of the ALU result and flags.
- Snapshots a 32-bit result plus its overflow flag on a load strobe.
- Time-multiplexes one 16-bit half (page) of the snapshot onto the 4-digit seven-segment display in hex; the page is toggled by a push button.
- Drives the board's AN/seg pins directly.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot (>=2); sets the scan rate.
- DIV_W, 16, width of the scan divider counter; must satisfy 2^DIV_W >= SCAN_DIV.

Ports:
- clk  input  1  system clock, only clock.
- rst  input  1  reset, synchronous, active-high.
- result  input  32  ALU result to display.
- ovf  input  1  ALU overflow flag accompanying result.
- load  input  1  one-cycle strobe; capture result/ovf.
- page_btn  input  1  raw asynchronous button level; each rising edge toggles the page.
- AN  output  4  digit enables, active-low; AN[0] is the rightmost digit.
- seg  output  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}.

Behaviour:
- Reset (rst=1 at a clk edge):
  - snap=0, snap_ovf=0, page=0, div_cnt=0, idx=0.
  - Synchronizer flops = 0.
  - AN=4'b1111, seg=8'hFF. Both outputs are registered.
- Capture: load=1 -> snap<=result, snap_ovf<=ovf at that edge. The new value appears on seg at most one cycle later, mid-slot, with no scan restart. Page is unchanged by load.
- Page button:
  - 2-flop synchronizer, then rising-edge detect on the synchronized level.
  - Each detected edge toggles page; held level has no further effect.
  - Edge detection latency is 3 cycles from page_btn rise to page toggle.
- Load and page edge in the same cycle: both take effect.
- Page selects the displayed window: page 0 -> snap[15:0]; page 1 -> snap[31:16].
- Scan timing:
  - div_cnt counts 0..SCAN_DIV-1 and wraps.
  - On wrap, idx <= idx+1 mod 4 (3 -> 0).
- Output register, updated every cycle from current idx/page/snap:
  - AN = ~(4'b0001 << idx).
  - seg[6:0] = hex glyph of nibble idx of the window.
- Decimal point (seg[7]) is lit (0) when:
  - idx==3 and page==1 (upper-page marker), or
  - idx==0 and snap_ovf==1.
  - Otherwise seg[7]=1.
- First cycle after reset release: AN=4'b1110, seg=8'hC0.
- Glyphs with dp off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- Reset asserted mid-scan overrides everything in that cycle; the scan restarts at idx 0.
- No combinational path from inputs to AN/seg.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Within the selected 4-nibble window, zero nibbles above the most significant nonzero nibble are blanked: AN=4'b1111 and seg=8'hFF for that slot.
  - Digit 0 is never blanked.
  - A slot carrying a lit dp is never blanked.
  - Slot timing is unchanged.
- Undefined: all four digits are always shown, including leading zeros.

Decomposition:
- Shared package seg_pkg:
  - 16-entry glyph constant table.
  - SEG_BLANK=8'hFF and AN_OFF=4'hF.
  - DP bit index 7.
- One sub-module, hex_to_seg: combinational 4-bit nibble -> 7-bit active-low glyph, reused by the ALU top.
- Synchronizer and edge detect stay inline.

Test Plan:
- Reset, SCAN_DIV=4 -> AN=1111 and seg=FF during reset; after release AN cycles 1110,1101,1011,0111 every 4 cycles and wraps; seg=C0 in every slot.
- load with result=32'h0000ABCD, ovf=0 -> slots 0..3 show 0xA1 (d), 0xC6 (C), 0x83 (b), 0x88 (A).
- load with result=32'h12340000, ovf=1, then page_btn rise -> after 3 cycles page=1:
  - Slot 0 shows 0x99 with dp lit, i.e. 0x19.
  - Slot 3 shows 0xF9 with dp lit, i.e. 0x79.
  - A second page_btn pulse returns to page 0: slot 0 shows 0x40.
- load and page_btn edge in the same cycle -> the new snapshot is shown on the toggled page; page_btn held high for 20 cycles toggles only once.
- Reset asserted at idx=2 mid-slot -> next cycle AN=1111; after release the scan restarts at AN=1110; snapshot and page are cleared.
- With LEADING_ZERO_BLANK_EN defined, result=32'h0000000F -> slots 1..3 AN=1111 and seg=FF, slot 0 seg=8E; with result=0, slot 0 still shows C0.
